// File: rtl/id_inst_queue.sv
// id_inst_queue
// -------------
// Instruction buffer between the IF stage and the ID-stage decoder. Fetch
// pushes up to FETCH_WIDTH instructions per cycle; decode sees the oldest
// ISSUE_WIDTH entries combinationally and consumes deq_count of them.
// The queue also tracks MIPS delay slots: deq_delayslot marks an entry whose
// predecessor in program order was a branch/jump. That predecessor may already
// have left the queue, in which case the answer comes from last_branch.
// A mispredict flush can keep the first surviving entry, which is the delay
// slot of the branch that was just dequeued.
//
// Handshake: enq_ready is a function of the occupancy before the clock edge
// only. Enqueued lanes are written at the edge when enq_ready=1 and flush=0,
// and become visible on deq_* one cycle later. deq_valid[i] means head+i is
// occupied. Decode consumes min(deq_count, count) entries at the edge, or none
// while stall=1.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   enq_valid[FW]             per-lane valid, contiguous from lane 0
//   enq_pc/inst/pred_addr     32 bits per lane, lane i at [32i+31:32i]
//   enq_is_branch[FW]         lane holds a branch/jump
//   enq_pred_taken[FW]        BTB taken prediction
//   enq_ready                 at least FETCH_WIDTH free slots
//   deq_valid[IW]             head+i occupied
//   deq_pc/inst/pred_addr     head entries in program order, 32 bits per lane
//   deq_pred_taken[IW]        stored prediction
//   deq_delayslot[IW]         entry is a delay slot
//   deq_count                 number of head entries consumed this cycle
//   stall                     decode stall, no entries consumed
//   flush, flush_keep_ds      discard entries, optionally keep the delay slot
//   count, full, empty        occupancy status
module id_inst_queue #(
    parameter int DEPTH       = 8,
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [FETCH_WIDTH-1:0]               enq_valid,
    input  logic [32*FETCH_WIDTH-1:0]            enq_pc,
    input  logic [32*FETCH_WIDTH-1:0]            enq_inst,
    input  logic [FETCH_WIDTH-1:0]               enq_is_branch,
    input  logic [FETCH_WIDTH-1:0]               enq_pred_taken,
    input  logic [32*FETCH_WIDTH-1:0]            enq_pred_addr,
    output logic                                 enq_ready,
    output logic [ISSUE_WIDTH-1:0]               deq_valid,
    output logic [32*ISSUE_WIDTH-1:0]            deq_pc,
    output logic [32*ISSUE_WIDTH-1:0]            deq_inst,
    output logic [32*ISSUE_WIDTH-1:0]            deq_pred_addr,
    output logic [ISSUE_WIDTH-1:0]               deq_pred_taken,
    output logic [ISSUE_WIDTH-1:0]               deq_delayslot,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]     deq_count,
    input  logic                                 stall,
    input  logic                                 flush,
    input  logic                                 flush_keep_ds,
    output logic [CNT_W-1:0]                     count,
    output logic                                 full,
    output logic                                 empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // Entry storage
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pa_mem   [DEPTH];
    logic        br_mem   [DEPTH];
    logic        pt_mem   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             last_branch;

    logic [FETCH_WIDTH-1:0] lane_ok;
    logic [CNT_W-1:0]       num_enq;
    logic                   do_enq;
    logic [CNT_W-1:0]       deq_req;
    logic [CNT_W-1:0]       eff_deq;
    logic [CNT_W-1:0]       remain;
    logic [PTR_W-1:0]       head_next;
    logic                   lb_next;

    // Status
    assign enq_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_WIDTH);
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

    // Accepted lanes: a lane counts only if every lower lane is valid too,
    // so a stray lane-1 valid without lane 0 is ignored.
    always_comb begin
        logic run;
        run     = 1'b1;
        lane_ok = '0;
        num_enq = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            run        = run & enq_valid[i];
            lane_ok[i] = run;
            num_enq    = num_enq + CNT_W'(run);
        end
    end

    assign do_enq = enq_ready && !flush;

    // Effective dequeue: clamped to the lane count and to the occupancy.
    always_comb begin
        deq_req = CNT_W'(deq_count);
        if (deq_req > CNT_W'(ISSUE_WIDTH)) begin
            deq_req = CNT_W'(ISSUE_WIDTH);
        end
        eff_deq = '0;
        if (!stall) begin
            eff_deq = (deq_req > count) ? count : deq_req;
        end
        remain    = count - eff_deq;
        head_next = head + PTR_W'(eff_deq);
        // last_branch follows the youngest consumed entry
        lb_next = last_branch;
        if (eff_deq != '0) begin
            lb_next = br_mem[head + PTR_W'(eff_deq - CNT_W'(1))];
        end
    end

    // Head window, visible with zero latency
    always_comb begin
        logic [PTR_W-1:0] idx;
        deq_valid      = '0;
        deq_pc         = '0;
        deq_inst       = '0;
        deq_pred_addr  = '0;
        deq_pred_taken = '0;
        deq_delayslot  = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            idx                    = head + PTR_W'(i);
            deq_valid[i]           = (count > CNT_W'(i));
            deq_pc[32*i +: 32]     = pc_mem[idx];
            deq_inst[32*i +: 32]   = inst_mem[idx];
            deq_pred_addr[32*i +: 32] = pa_mem[idx];
            deq_pred_taken[i]      = pt_mem[idx];
            if (i == 0) begin
                deq_delayslot[i] = last_branch;
            end else begin
                deq_delayslot[i] = br_mem[idx - PTR_W'(1)];
            end
        end
    end

    // Entry writes; contents need no reset since deq_valid gates them.
    always_ff @(posedge clk) begin
        if (!rst && do_enq) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (lane_ok[i]) begin
                    pc_mem[tail + PTR_W'(i)]   <= enq_pc[32*i +: 32];
                    inst_mem[tail + PTR_W'(i)] <= enq_inst[32*i +: 32];
                    pa_mem[tail + PTR_W'(i)]   <= enq_pred_addr[32*i +: 32];
                    br_mem[tail + PTR_W'(i)]   <= enq_is_branch[i];
                    pt_mem[tail + PTR_W'(i)]   <= enq_pred_taken[i];
                end
            end
        end
    end

    // Pointers, occupancy and delay-slot tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            last_branch <= 1'b0;
        end else if (flush) begin
            // The flush acts on the state left after this cycle's dequeue.
            if (flush_keep_ds && (remain != '0)) begin
                head        <= head_next;
                tail        <= head_next + PTR_W'(1);
                count       <= CNT_W'(1);
                last_branch <= lb_next;
            end else begin
                head        <= tail;
                count       <= '0;
                // Keeping the dequeue update lets a refetched delay slot
                // still be flagged.
                last_branch <= flush_keep_ds ? lb_next : 1'b0;
            end
        end else begin
            head        <= head_next;
            last_branch <= lb_next;
            if (do_enq) begin
                tail  <= tail + PTR_W'(num_enq);
                count <= remain + num_enq;
            end else begin
                count <= remain;
            end
        end
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// Directed bench for id_inst_queue with hand-computed expectations.
module tb_id_inst_queue;

    localparam int DEPTH = 8;
    localparam int FW    = 2;
    localparam int IW    = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [FW-1:0]     enq_valid;
    logic [32*FW-1:0]  enq_pc;
    logic [32*FW-1:0]  enq_inst;
    logic [FW-1:0]     enq_is_branch;
    logic [FW-1:0]     enq_pred_taken;
    logic [32*FW-1:0]  enq_pred_addr;
    logic              enq_ready;
    logic [IW-1:0]     deq_valid;
    logic [32*IW-1:0]  deq_pc;
    logic [32*IW-1:0]  deq_inst;
    logic [32*IW-1:0]  deq_pred_addr;
    logic [IW-1:0]     deq_pred_taken;
    logic [IW-1:0]     deq_delayslot;
    logic [1:0]        deq_count;
    logic              stall;
    logic              flush;
    logic              flush_keep_ds;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    int checks   = 0;
    int failures = 0;

    id_inst_queue #(
        .DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_inst(enq_inst),
        .enq_is_branch(enq_is_branch), .enq_pred_taken(enq_pred_taken),
        .enq_pred_addr(enq_pred_addr), .enq_ready(enq_ready),
        .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_inst(deq_inst),
        .deq_pred_addr(deq_pred_addr), .deq_pred_taken(deq_pred_taken),
        .deq_delayslot(deq_delayslot), .deq_count(deq_count),
        .stall(stall), .flush(flush), .flush_keep_ds(flush_keep_ds),
        .count(count), .full(full), .empty(empty)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive all inputs; inst and pred_addr are derived from pc.
    task automatic set_in(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                          input logic [1:0] br, input logic [1:0] dc,
                          input logic st, input logic fl, input logic kd);
        enq_valid      = v;
        enq_pc         = {p1, p0};
        enq_inst       = {~p1, ~p0};
        enq_is_branch  = br;
        enq_pred_taken = br;
        enq_pred_addr  = {p1 + 32'h40, p0 + 32'h40};
        deq_count      = dc;
        stall          = st;
        flush          = fl;
        flush_keep_ds  = kd;
    endtask

    task automatic idle();
        set_in(2'b00, 32'h0, 32'h0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ready", 32'(enq_ready), 32'd1);
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);

        // Fill to full with two-lane enqueues
        set_in(2'b11, 32'h100, 32'h104, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("fill1_count", 32'(count), 32'd2);
        chk("fill1_valid", 32'(deq_valid), 32'd3);
        chk("fill1_pc0", deq_pc[31:0], 32'h100);
        chk("fill1_pc1", deq_pc[63:32], 32'h104);
        set_in(2'b11, 32'h108, 32'h10C, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(2'b11, 32'h110, 32'h114, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("fill3_count", 32'(count), 32'd6);
        chk("fill3_ready", 32'(enq_ready), 32'd1);
        set_in(2'b11, 32'h118, 32'h11C, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("fill4_count", 32'(count), 32'd8);
        chk("fill4_full", 32'(full), 32'd1);
        chk("fill4_ready", 32'(enq_ready), 32'd0);
        set_in(2'b11, 32'h120, 32'h124, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("over_count", 32'(count), 32'd8);

        // Drain two per cycle, in order
        for (int k = 0; k < 4; k++) begin
            set_in(2'b00, 32'h0, 32'h0, 2'b00, 2'd2, 1'b0, 1'b0, 1'b0);
            chk("drain_pc0", deq_pc[31:0], 32'h100 + 32'(8 * k));
            chk("drain_pc1", deq_pc[63:32], 32'h104 + 32'(8 * k));
            chk("drain_inst0", deq_inst[31:0], ~(32'h100 + 32'(8 * k)));
            step();
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_valid", 32'(deq_valid), 32'd0);

        // Offset pointers by one, then refill so the tail wraps
        set_in(2'b01, 32'h500, 32'h0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("single_count", 32'(count), 32'd1);
        chk("single_valid", 32'(deq_valid), 32'd1);
        set_in(2'b00, 32'h0, 32'h0, 2'b00, 2'd3, 1'b0, 1'b0, 1'b0);
        step();
        chk("single_empty", 32'(empty), 32'd1);
        // Lane 1 without lane 0 is ignored
        set_in(2'b10, 32'h5A0, 32'h5A4, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("noncontig_count", 32'(count), 32'd0);
        for (int k = 0; k < 4; k++) begin
            set_in(2'b11, 32'h600 + 32'(8 * k), 32'h604 + 32'(8 * k), 2'b00, 2'd0,
                   1'b0, 1'b0, 1'b0);
            step();
        end
        chk("wrap_count", 32'(count), 32'd8);
        for (int k = 0; k < 4; k++) begin
            set_in(2'b00, 32'h0, 32'h0, 2'b00, 2'd2, 1'b0, 1'b0, 1'b0);
            chk("wrap_pc0", deq_pc[31:0], 32'h600 + 32'(8 * k));
            chk("wrap_pc1", deq_pc[63:32], 32'h604 + 32'(8 * k));
            step();
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        // Delay slot, one dequeue per cycle
        set_in(2'b11, 32'h200, 32'h204, 2'b01, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("br_ds", 32'(deq_delayslot), 32'd2);
        chk("br_pt", 32'(deq_pred_taken), 32'd1);
        chk("br_pa0", deq_pred_addr[31:0], 32'h240);
        set_in(2'b00, 32'h0, 32'h0, 2'b00, 2'd1, 1'b0, 1'b0, 1'b0);
        step();
        chk("ds_pc0", deq_pc[31:0], 32'h204);
        chk("ds_flag0", 32'(deq_delayslot[0]), 32'd1);
        chk("ds_count", 32'(count), 32'd1);
        step();
        chk("ds_after_empty", 32'(empty), 32'd1);
        chk("ds_after_flag0", 32'(deq_delayslot[0]), 32'd0);

        // Delay slot, both consumed in one cycle
        set_in(2'b11, 32'h200, 32'h204, 2'b01, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(2'b00, 32'h0, 32'h0, 2'b00, 2'd2, 1'b0, 1'b0, 1'b0);
        chk("pair_ds1", 32'(deq_delayslot[1]), 32'd1);
        chk("pair_ds0", 32'(deq_delayslot[0]), 32'd0);
        step();
        chk("pair_empty", 32'(empty), 32'd1);

        // Stall blocks dequeue but not enqueue; enq_ready uses pre-edge count
        set_in(2'b11, 32'h700, 32'h704, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(2'b11, 32'h708, 32'h70C, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("stall_pre_count", 32'(count), 32'd4);
        set_in(2'b11, 32'h710, 32'h714, 2'b00, 2'd2, 1'b1, 1'b0, 1'b0);
        step();
        chk("stall_count", 32'(count), 32'd6);
        chk("stall_pc0", deq_pc[31:0], 32'h700);
        set_in(2'b11, 32'h718, 32'h71C, 2'b00, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        chk("deqenq_count", 32'(count), 32'd6);
        chk("deqenq_pc0", deq_pc[31:0], 32'h708);
        set_in(2'b11, 32'h720, 32'h724, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("refull", 32'(full), 32'd1);
        set_in(2'b11, 32'h728, 32'h72C, 2'b00, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        chk("full_deq_count", 32'(count), 32'd6);
        chk("full_deq_pc0", deq_pc[31:0], 32'h710);
        set_in(2'b00, 32'h0, 32'h0, 2'b00, 2'd0, 1'b0, 1'b1, 1'b0);
        step();
        chk("flush_empty", 32'(empty), 32'd1);

        // Flush keeping the delay slot; the flush-cycle enqueue is dropped
        set_in(2'b11, 32'h300, 32'h304, 2'b01, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(2'b01, 32'h308, 32'h0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("kds_pre_count", 32'(count), 32'd3);
        set_in(2'b11, 32'h900, 32'h904, 2'b00, 2'd1, 1'b0, 1'b1, 1'b1);
        step();
        chk("kds_count", 32'(count), 32'd1);
        chk("kds_pc0", deq_pc[31:0], 32'h304);
        chk("kds_valid", 32'(deq_valid), 32'd1);
        chk("kds_ds0", 32'(deq_delayslot[0]), 32'd1);
        set_in(2'b00, 32'h0, 32'h0, 2'b00, 2'd1, 1'b0, 1'b0, 1'b0);
        step();
        chk("kds_drain_empty", 32'(empty), 32'd1);

        // Same case without keep_ds
        set_in(2'b11, 32'h300, 32'h304, 2'b01, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(2'b01, 32'h308, 32'h0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(2'b00, 32'h0, 32'h0, 2'b00, 2'd1, 1'b0, 1'b1, 1'b0);
        step();
        chk("fl_empty", 32'(empty), 32'd1);
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_ds0", 32'(deq_delayslot[0]), 32'd0);

        // Stall with keep_ds flush: effective dequeue 0, head entry kept
        set_in(2'b11, 32'h300, 32'h304, 2'b01, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(2'b00, 32'h0, 32'h0, 2'b00, 2'd2, 1'b1, 1'b1, 1'b1);
        step();
        chk("stfl_count", 32'(count), 32'd1);
        chk("stfl_pc0", deq_pc[31:0], 32'h300);
        chk("stfl_ds0", 32'(deq_delayslot[0]), 32'd0);

        // keep_ds with nothing remaining: refetched delay slot still flagged
        set_in(2'b00, 32'h0, 32'h0, 2'b00, 2'd1, 1'b0, 1'b1, 1'b1);
        step();
        chk("kdsnone_empty", 32'(empty), 32'd1);
        chk("kdsnone_ds0", 32'(deq_delayslot[0]), 32'd1);
        set_in(2'b01, 32'h304, 32'h0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("refetch_pc0", deq_pc[31:0], 32'h304);
        chk("refetch_ds0", 32'(deq_delayslot[0]), 32'd1);

        // Reset mid-operation with enqueue and flush asserted
        set_in(2'b11, 32'hA00, 32'hA04, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(2'b11, 32'hA08, 32'hA0C, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("prerst_count", 32'(count), 32'd5);
        rst = 1'b1;
        set_in(2'b11, 32'hB00, 32'hB04, 2'b00, 2'd1, 1'b0, 1'b1, 1'b0);
        step();
        rst = 1'b0;
        idle();
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_ready", 32'(enq_ready), 32'd1);
        chk("midrst_valid", 32'(deq_valid), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_ds0", 32'(deq_delayslot[0]), 32'd0);
        step();
        chk("postrst_count", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
